iob_diff_sched: RTL and testbench

Time-multiplexed differentiator scheduler: shares a single registered subtractor among `N_CH` sample streams and keeps one previous-sample register per channel, so each stream sees `data - previous_data` as if it had its own differentiator. A round-robin arbiter picks one valid channel per cycle. The result goes out on a single valid/ready stream tagged with the channel index. It sits between multi-channel sample sources (ADC front-ends, counters) and a shared downstream consumer.

---
 rtl/iob_diff_sched.sv | 93 +++++++++
 tb/tb_iob_diff_sched.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/iob_diff_sched.sv
// Shared-subtractor differentiator for N_CH sample streams: round-robin grant,
// one previous-sample register per channel, single registered valid/ready output.
module iob_diff_sched #(
  parameter int                DATA_W  = 32,
  parameter int                N_CH    = 4,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                      clk_i,
  input  logic                      cke_i,
  input  logic                      arst_n_i,
  input  logic                      en_i,
  input  logic [N_CH-1:0]           clr_i,
  input  logic [N_CH-1:0]           in_valid_i,
  input  logic [N_CH*DATA_W-1:0]    in_data_i,
  output logic [N_CH-1:0]           in_ready_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_W-1:0]         out_data_o,
  output logic [$clog2(N_CH)-1:0]   out_ch_o
);
  localparam int CH_W = $clog2(N_CH);

  logic [DATA_W-1:0] ch_data [N_CH];
  logic [DATA_W-1:0] prev_reg [N_CH];
  logic [CH_W-1:0]   last_reg;
  logic [CH_W-1:0]   pick_ch;
  logic [CH_W-1:0]   scan_ch;
  logic              pick_found;
  logic              issue;
  logic              accept;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] diff;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign ch_data[gi] = in_data_i[gi*DATA_W +: DATA_W];
  end

  // Scan starts one past the last winner and wraps, so an idle channel costs no cycle.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    scan_ch    = '0;
    for (int i = 1; i <= N_CH; i++) begin
      scan_ch = CH_W'((int'(last_reg) + i) % N_CH);
      if (!pick_found && in_valid_i[scan_ch]) begin
        pick_found = 1'b1;
        pick_ch    = scan_ch;
      end
    end
  end

  // Reset is folded in so the ready lines are quiet while the block is held in reset.
  assign issue  = arst_n_i & cke_i & en_i & (~out_valid_o | out_ready_i);
  assign accept = issue & pick_found;

  always_comb begin
    in_ready_o = '0;
    if (accept) in_ready_o[pick_ch] = 1'b1;
  end

  // A clear in the same cycle as an accept makes the difference start from RST_VAL.
  assign base = clr_i[pick_ch] ? RST_VAL : prev_reg[pick_ch];
  assign diff = ch_data[pick_ch] - base;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int k = 0; k < N_CH; k++) prev_reg[k] <= RST_VAL;
    end else if (cke_i) begin
      for (int k = 0; k < N_CH; k++) begin
        if (accept && pick_ch == CH_W'(k)) prev_reg[k] <= ch_data[k];
        else if (clr_i[k])                 prev_reg[k] <= RST_VAL;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
      last_reg    <= CH_W'(N_CH - 1);
    end else if (cke_i) begin
      if (accept) begin
        out_valid_o <= 1'b1;
        out_data_o  <= diff;
        out_ch_o    <= pick_ch;
        last_reg    <= pick_ch;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_iob_diff_sched.sv
// Scoreboard bench for iob_diff_sched (DATA_W=8, N_CH=4): a reference model of the
// arbiter and history bank predicts ready and results; outputs are popped on handshake.
module tb_iob_diff_sched;
  logic        clk = 1'b0;
  logic        cke_i = 1'b1;
  logic        arst_n_i = 1'b0;
  logic        en_i = 1'b1;
  logic [3:0]  clr_i = '0;
  logic [3:0]  in_valid_i = '0;
  logic [31:0] in_data_i = '0;
  logic [3:0]  in_ready_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [7:0]  out_data_o;
  logic [1:0]  out_ch_o;

  iob_diff_sched #(.DATA_W(8), .N_CH(4), .RST_VAL(8'd0)) dut (
    .clk_i(clk), .cke_i(cke_i), .arst_n_i(arst_n_i), .en_i(en_i), .clr_i(clr_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_ch_o(out_ch_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] ch; logic [7:0] d; } res_t;
  res_t       sb_q[$];
  logic [7:0] prev_m [4];
  int         last_m;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    for (int k = 0; k < 4; k++) prev_m[k] = 8'd0;
    last_m = 3;
  endtask

  // Entered at posedge+1; drives inputs, checks mid-cycle, models the next edge.
  task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic [3:0] clr,
                       input logic ordy, input logic en, input logic cke);
    logic       issue, found;
    int         c;
    logic [3:0] exp_rdy;
    logic [7:0] dc, base;
    res_t       r;
    in_valid_i = v; in_data_i = d; clr_i = clr; out_ready_i = ordy; en_i = en; cke_i = cke;
    #3;
    issue = cke && en && (sb_q.size() == 0 || ordy);
    found = 1'b0; c = 0;
    for (int i = 1; i <= 4; i++) begin
      if (!found && v[(last_m + i) % 4]) begin
        found = 1'b1;
        c = (last_m + i) % 4;
      end
    end
    exp_rdy = (issue && found) ? (4'b0001 << c) : 4'b0000;
    check("ready", in_ready_o, exp_rdy);
    check("out_valid", out_valid_o, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      check("out_ch", out_ch_o, sb_q[0].ch);
      check("out_data", out_data_o, sb_q[0].d);
      if (cke && ordy) void'(sb_q.pop_front());
    end
    if (cke) begin
      if (issue && found) begin
        dc   = d[c*8 +: 8];
        base = clr[c] ? 8'd0 : prev_m[c];
        r.ch = 2'(c);
        r.d  = dc - base;
        sb_q.push_back(r);
        prev_m[c] = dc;
        last_m = c;
      end
      for (int k = 0; k < 4; k++)
        if (clr[k] && !(issue && found && k == c)) prev_m[k] = 8'd0;
    end
    @(posedge clk); #1;
  endtask

  // Asserted between edges: outputs must drop without waiting for a clock.
  task automatic do_reset();
    in_valid_i = 4'hF; out_ready_i = 1'b1; clr_i = '0; en_i = 1'b1; cke_i = 1'b1;
    #1 arst_n_i = 1'b0;
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_ch", out_ch_o, 0);
    check("rst_ready", in_ready_o, 0);
    model_reset();
    #2 arst_n_i = 1'b1;
    in_valid_i = '0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(4'b0000, 32'd0, 4'b0000, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Basic difference on ch0
    cycle(4'b0001, 32'd10, 4'b0000, 1'b1, 1'b1, 1'b1);
    cycle(4'b0001, 32'd25, 4'b0000, 1'b1, 1'b1, 1'b1);
    drain(2);

    // Round-robin with all channels valid, constant values 1..4
    do_reset();
    for (int i = 0; i < 6; i++) cycle(4'b1111, 32'h04030201, 4'b0000, 1'b1, 1'b1, 1'b1);
    drain(2);

    // Backpressure with ch1 and ch3 valid, data changing every cycle
    for (int i = 0; i < 8; i++)
      cycle(4'b1010, {8'(40 + i), 8'd0, 8'(20 + i), 8'd0}, 4'b0000,
            !(i >= 1 && i <= 3), 1'b1, 1'b1);
    drain(2);

    // Global enable low still lets a pending output drain
    cycle(4'b0001, 32'd5, 4'b0000, 1'b0, 1'b1, 1'b1);
    cycle(4'b0001, 32'd6, 4'b0000, 1'b1, 1'b0, 1'b1);
    drain(1);

    // Clock enable low freezes everything and ignores clear
    cycle(4'b0001, 32'd9, 4'b0000, 1'b0, 1'b1, 1'b1);
    cycle(4'b0001, 32'd1, 4'b0001, 1'b1, 1'b1, 1'b0);
    cycle(4'b0000, 32'd0, 4'b0000, 1'b1, 1'b1, 1'b1);
    cycle(4'b0001, 32'd12, 4'b0000, 1'b1, 1'b1, 1'b1);
    drain(2);

    // Wrap-around arithmetic
    do_reset();
    cycle(4'b0010, {8'd0, 8'd0, 8'd250, 8'd0}, 4'b0000, 1'b1, 1'b1, 1'b1);
    cycle(4'b0010, {8'd0, 8'd0, 8'd5, 8'd0}, 4'b0000, 1'b1, 1'b1, 1'b1);
    cycle(4'b0100, {8'd0, 8'd5, 8'd0, 8'd0}, 4'b0000, 1'b1, 1'b1, 1'b1);
    cycle(4'b0100, {8'd0, 8'd250, 8'd0, 8'd0}, 4'b0000, 1'b1, 1'b1, 1'b1);
    drain(2);

    // Clear collision on ch2, then clear without accept on ch1
    cycle(4'b0100, {8'd0, 8'd30, 8'd0, 8'd0}, 4'b0000, 1'b1, 1'b1, 1'b1);
    cycle(4'b0100, {8'd0, 8'd40, 8'd0, 8'd0}, 4'b0100, 1'b1, 1'b1, 1'b1);
    cycle(4'b0100, {8'd0, 8'd45, 8'd0, 8'd0}, 4'b0000, 1'b1, 1'b1, 1'b1);
    cycle(4'b0000, 32'd0, 4'b0010, 1'b1, 1'b1, 1'b1);
    cycle(4'b0010, {8'd0, 8'd0, 8'd17, 8'd0}, 4'b0000, 1'b1, 1'b1, 1'b1);
    drain(2);

    // Asynchronous reset with a pending output and ch0 history of 100
    do_reset();
    cycle(4'b0001, 32'd100, 4'b0000, 1'b0, 1'b1, 1'b1);
    cycle(4'b0000, 32'd0, 4'b0000, 1'b0, 1'b1, 1'b1);
    do_reset();
    cycle(4'b1111, {8'd9, 8'd9, 8'd9, 8'd7}, 4'b0000, 1'b1, 1'b1, 1'b1);
    drain(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
